input_conditioner: RTL and testbench



---
 rtl/input_conditioner.sv | 161 ++++++++++++++++
 tb/tb_input_conditioner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner
//   Player-button front end: per-button 2-flop synchronizer and debouncer,
//   registered rise/fall pulses, and the jump-charge state machine that
//   turns a held jump button into one jump_fire pulse carrying a charge.
//
// Ports
//   sys_clk        in   system clock
//   sys_rst_n      in   asynchronous active-low reset
//   btn_raw        in   raw asynchronous buttons, active-high
//   char_tick      in   one-cycle character-clock enable
//   jump_enable    in   character grounded / allowed to charge
//   btn_level      out  debounced levels
//   btn_rise       out  one-cycle pulse on a debounced 0->1
//   btn_fall       out  one-cycle pulse on a debounced 1->0
//   jump_charging  out  high while charging
//   jump_charge    out  live charge value
//   jump_fire      out  one-cycle pulse when a charged jump is released
//   jump_power     out  charge latched at the last fire
module input_conditioner #(
    parameter int BTN_NUM         = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter int JUMP_IDX        = 4,
    parameter int CHARGE_WIDTH    = 6,
    parameter int MAX_CHARGE      = 63
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [BTN_NUM-1:0]      btn_raw,
    input  logic                    char_tick,
    input  logic                    jump_enable,
    output logic [BTN_NUM-1:0]      btn_level,
    output logic [BTN_NUM-1:0]      btn_rise,
    output logic [BTN_NUM-1:0]      btn_fall,
    output logic                    jump_charging,
    output logic [CHARGE_WIDTH-1:0] jump_charge,
    output logic                    jump_fire,
    output logic [CHARGE_WIDTH-1:0] jump_power
);

    localparam logic [CNT_WIDTH-1:0]    CNT_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CHARGE_WIDTH-1:0] CHARGE_MAX = CHARGE_WIDTH'(MAX_CHARGE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHARGE,
        ST_FIRE
    } jump_state_e;

    logic [BTN_NUM-1:0]   sync1_q;
    logic [BTN_NUM-1:0]   sync2_q;
    logic [CNT_WIDTH-1:0] cnt_q [BTN_NUM];
    logic [CNT_WIDTH-1:0] cnt_d [BTN_NUM];
    logic [BTN_NUM-1:0]   level_q;
    logic [BTN_NUM-1:0]   level_d;
    logic [BTN_NUM-1:0]   level_prev_q;
    logic [BTN_NUM-1:0]   rise_q;
    logic [BTN_NUM-1:0]   fall_q;

    jump_state_e             state_q;
    logic                    charging_q;
    logic [CHARGE_WIDTH-1:0] charge_q;
    logic                    fire_q;
    logic [CHARGE_WIDTH-1:0] power_q;

    // Debounce: count consecutive cycles where the synchronized input
    // disagrees with the accepted level; accept on the last count.
    always_comb begin
        level_d = level_q;
        for (int unsigned i = 0; i < BTN_NUM; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            for (int unsigned i = 0; i < BTN_NUM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            rise_q       <= level_q & ~level_prev_q;
            fall_q       <= ~level_q & level_prev_q;
            for (int unsigned i = 0; i < BTN_NUM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Jump FSM. In CHARGE the release wins over an enable drop, which wins
    // over a tick; a tick coinciding with the release is dropped.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            charging_q <= 1'b0;
            charge_q   <= '0;
            fire_q     <= 1'b0;
            power_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_q[JUMP_IDX] && jump_enable) begin
                        state_q    <= ST_CHARGE;
                        charging_q <= 1'b1;
                        charge_q   <= '0;
                    end
                end
                ST_CHARGE: begin
                    if (fall_q[JUMP_IDX]) begin
                        state_q    <= ST_FIRE;
                        charging_q <= 1'b0;
                        fire_q     <= 1'b1;
                        power_q    <= charge_q;
                    end else if (!jump_enable) begin
                        state_q    <= ST_IDLE;
                        charging_q <= 1'b0;
                        charge_q   <= '0;
                    end else if (char_tick && (charge_q != CHARGE_MAX)) begin
                        charge_q <= charge_q + 1'b1;
                    end
                end
                ST_FIRE: begin
                    state_q  <= ST_IDLE;
                    fire_q   <= 1'b0;
                    charge_q <= '0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    charging_q <= 1'b0;
                    fire_q     <= 1'b0;
                    charge_q   <= '0;
                end
            endcase
        end
    end

    assign btn_level     = level_q;
    assign btn_rise      = rise_q;
    assign btn_fall      = fall_q;
    assign jump_charging = charging_q;
    assign jump_charge   = charge_q;
    assign jump_fire     = fire_q;
    assign jump_power    = power_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//   Directed bench for input_conditioner with a short debounce window.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_input_conditioner;

    localparam int BTN_NUM      = 5;
    localparam int CHARGE_WIDTH = 6;
    localparam int JUMP_IDX     = 4;

    logic                    sys_clk;
    logic                    sys_rst_n;
    logic [BTN_NUM-1:0]      btn_raw;
    logic                    char_tick;
    logic                    jump_enable;
    logic [BTN_NUM-1:0]      btn_level;
    logic [BTN_NUM-1:0]      btn_rise;
    logic [BTN_NUM-1:0]      btn_fall;
    logic                    jump_charging;
    logic [CHARGE_WIDTH-1:0] jump_charge;
    logic                    jump_fire;
    logic [CHARGE_WIDTH-1:0] jump_power;

    int unsigned n_checks;
    int unsigned n_passed;

    input_conditioner #(
        .BTN_NUM         (BTN_NUM),
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (3),
        .JUMP_IDX        (JUMP_IDX),
        .CHARGE_WIDTH    (CHARGE_WIDTH),
        .MAX_CHARGE      (63)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .btn_raw       (btn_raw),
        .char_tick     (char_tick),
        .jump_enable   (jump_enable),
        .btn_level     (btn_level),
        .btn_rise      (btn_rise),
        .btn_fall      (btn_fall),
        .jump_charging (jump_charging),
        .jump_charge   (jump_charge),
        .jump_fire     (jump_fire),
        .jump_power    (jump_power)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Raw press -> level after 6 edges, rise after 7, CHARGE after 8.
    task automatic press_jump();
        btn_raw[JUMP_IDX] = 1'b1;
        step(7);
        check("press_rise", 32'(btn_rise[JUMP_IDX]), 32'd1);
        check("press_not_yet_charging", 32'(jump_charging), 32'd0);
        step(1);
        check("press_charging", 32'(jump_charging), 32'd1);
        check("press_charge0", 32'(jump_charge), 32'd0);
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            char_tick = 1'b1;
            step(1);
            char_tick = 1'b0;
        end
    endtask

    // Release -> fall visible after 7 edges, FIRE after 8, IDLE after 9.
    task automatic release_jump(input logic tick_at_fall, input int unsigned exp_power);
        btn_raw[JUMP_IDX] = 1'b0;
        step(7);
        check("release_fall", 32'(btn_fall[JUMP_IDX]), 32'd1);
        check("release_no_fire_yet", 32'(jump_fire), 32'd0);
        char_tick = tick_at_fall;
        step(1);
        char_tick = 1'b0;
        check("fire_pulse", 32'(jump_fire), 32'd1);
        check("fire_power", 32'(jump_power), exp_power);
        check("fire_not_charging", 32'(jump_charging), 32'd0);
        step(1);
        check("fire_end", 32'(jump_fire), 32'd0);
        check("fire_charge_cleared", 32'(jump_charge), 32'd0);
        check("fire_power_held", 32'(jump_power), exp_power);
    endtask

    initial begin
        logic seen_fire;
        logic seen_bad;
        n_checks    = 0;
        n_passed    = 0;
        sys_rst_n   = 1'b0;
        btn_raw     = '0;
        char_tick   = 1'b0;
        jump_enable = 1'b1;

        step(2);
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_rise", 32'(btn_rise), 32'd0);
        check("rst_fall", 32'(btn_fall), 32'd0);
        check("rst_charging", 32'(jump_charging), 32'd0);
        check("rst_charge", 32'(jump_charge), 32'd0);
        check("rst_fire", 32'(jump_fire), 32'd0);
        check("rst_power", 32'(jump_power), 32'd0);
        sys_rst_n = 1'b1;
        step(2);

        // Debounced press on button 2
        btn_raw[2] = 1'b1;
        step(5);
        check("deb_level_edge5", 32'(btn_level[2]), 32'd0);
        step(1);
        check("deb_level_edge6", 32'(btn_level[2]), 32'd1);
        check("deb_rise_edge6", 32'(btn_rise[2]), 32'd0);
        step(1);
        check("deb_rise_edge7", 32'(btn_rise[2]), 32'd1);
        check("deb_fall_edge7", 32'(btn_fall[2]), 32'd0);
        step(1);
        check("deb_rise_edge8", 32'(btn_rise[2]), 32'd0);
        check("deb_fall_edge8", 32'(btn_fall[2]), 32'd0);
        check("deb_level_hold", 32'(btn_level[2]), 32'd1);

        // 3-high / 3-low glitches on button 0 never get through
        seen_bad = 1'b0;
        for (int r = 0; r < 5; r++) begin
            btn_raw[0] = 1'b1;
            for (int c = 0; c < 3; c++) begin
                step(1);
                if (btn_level[0] || btn_rise[0]) seen_bad = 1'b1;
            end
            btn_raw[0] = 1'b0;
            for (int c = 0; c < 3; c++) begin
                step(1);
                if (btn_level[0] || btn_rise[0]) seen_bad = 1'b1;
            end
        end
        step(6);
        if (btn_level[0] || btn_rise[0]) seen_bad = 1'b1;
        check("glitch_rejected", 32'(seen_bad), 32'd0);

        // Charge 10 ticks, fire with 10
        press_jump();
        for (int unsigned k = 1; k <= 10; k++) begin
            ticks(1);
            check($sformatf("charge_%0d", k), 32'(jump_charge), k);
        end
        release_jump(1'b0, 10);

        // Saturation at 63
        step(4);
        press_jump();
        ticks(63);
        check("sat_63", 32'(jump_charge), 32'd63);
        ticks(17);
        check("sat_80", 32'(jump_charge), 32'd63);
        release_jump(1'b0, 63);

        // Abort on enable drop
        step(4);
        press_jump();
        ticks(5);
        check("abort_charge5", 32'(jump_charge), 32'd5);
        jump_enable = 1'b0;
        step(1);
        check("abort_idle", 32'(jump_charging), 32'd0);
        check("abort_charge0", 32'(jump_charge), 32'd0);
        check("abort_no_fire", 32'(jump_fire), 32'd0);
        jump_enable = 1'b1;
        ticks(3);
        check("abort_tick_ignored", 32'(jump_charge), 32'd0);
        btn_raw[JUMP_IDX] = 1'b0;
        seen_fire = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            if (jump_fire || jump_charging) seen_fire = 1'b1;
        end
        check("abort_release_no_fire", 32'(seen_fire), 32'd0);
        check("abort_power_kept", 32'(jump_power), 32'd63);

        // Release coinciding with a tick
        press_jump();
        ticks(7);
        check("coin_charge7", 32'(jump_charge), 32'd7);
        release_jump(1'b1, 7);

        // Asynchronous reset mid-charge
        step(4);
        press_jump();
        ticks(3);
        check("rstmid_charge3", 32'(jump_charge), 32'd3);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("rstmid_level", 32'(btn_level), 32'd0);
        check("rstmid_charging", 32'(jump_charging), 32'd0);
        check("rstmid_charge", 32'(jump_charge), 32'd0);
        check("rstmid_power", 32'(jump_power), 32'd0);
        check("rstmid_fire", 32'(jump_fire), 32'd0);
        btn_raw[JUMP_IDX] = 1'b0;
        step(1);
        sys_rst_n = 1'b1;
        seen_fire = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (jump_fire || jump_charging || btn_level[JUMP_IDX]) seen_fire = 1'b1;
        end
        check("rstmid_no_fire_after", 32'(seen_fire), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
